// File: rtl/data_mem_arb.sv
// Two-port round-robin arbiter in front of a word-wide data memory.
// Sub-word stores are turned into a read-modify-write sequence; one transaction in flight.
module data_mem_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [3:0]            req0_be,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [3:0]            req1_be,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned BE_WIDTH    = 4;
  localparam int unsigned WADDR_WIDTH = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   last_grant_q;
  logic                   owner_q;
  logic                   we_q;
  logic [WADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [BE_WIDTH-1:0]    be_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [DATA_WIDTH-1:0]  merged_q;

  logic                   grant;
  logic                   take;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [BE_WIDTH-1:0]    sel_be;
  logic                   full_wr;
  logic                   partial_wr;
  logic [DATA_WIDTH-1:0]  merge_c;

  // Round-robin pick: a lone requester wins, contention goes to the port not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
  end

  // Flops never see rst through take: they are held in reset while it is high.
  assign take       = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = take && !grant && !rst;
  assign req1_ready = take && grant && !rst;

  assign sel_we    = grant ? req1_we    : req0_we;
  assign sel_addr  = grant ? req1_addr  : req0_addr;
  assign sel_wdata = grant ? req1_wdata : req0_wdata;
  assign sel_be    = grant ? req1_be    : req0_be;

  assign full_wr    = we_q && (be_q == 4'hF);
  assign partial_wr = we_q && (be_q != 4'h0) && (be_q != 4'hF);

  // Lane merge of new write data over the word currently in memory.
  always_comb begin
    merge_c = mem_rdata;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be_q[i]) begin
        merge_c[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // Memory side decodes straight from state so an async reset cancels a pending write.
  assign mem_ren   = (state_q == ACCESS);
  assign mem_wen   = ((state_q == ACCESS) && full_wr) || (state_q == MERGE_WR);
  assign mem_addr  = ((state_q == ACCESS) || (state_q == MERGE_WR)) ? {addr_q, 2'b00}
                                                                    : '0;
  assign mem_wdata = (state_q == MERGE_WR)              ? merged_q :
                     ((state_q == ACCESS) && full_wr)   ? wdata_q  : '0;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
      merged_q     <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            we_q         <= sel_we;
            addr_q       <= sel_addr[ADDR_WIDTH-1:2];
            wdata_q      <= sel_wdata;
            be_q         <= sel_be;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= mem_rdata;
          if (partial_wr) begin
            merged_q <= merge_c;
            state_q  <= MERGE_WR;
          end else begin
            // Response pulse lands in RESP, the cycle after this edge.
            if (owner_q) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= mem_rdata;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= mem_rdata;
            end
            state_q <= RESP;
          end
        end
        MERGE_WR: begin
          if (owner_q) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= rdata_q;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= rdata_q;
          end
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_arb.md
Name: data_mem_arb

Overview:
- Two-requester arbiter and access sequencer in front of the word-organised data memory.
- Port 0 is the core load/store unit; port 1 is a DMA/debug master.
- The memory accepts only full-word writes with combinational read, so this block converts byte-enabled sub-word stores into a read-modify-write sequence.
- Round-robin arbitration; one transaction in flight at a time; every accepted request gets exactly one response pulse.

Parameters:
- ADDR_WIDTH, 32, byte address width of requester and memory address ports
- DATA_WIDTH, 32, word width; fixed at 32 (byte enables are 4 bits)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0_valid / req1_valid  in  1  request valid, ports 0/1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data, lane-aligned
- req0_be / req1_be  in  4  byte enables; bit i selects byte lane i
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data; for writes, the pre-write word
- mem_wen  out  1  memory write enable
- mem_ren  out  1  memory read enable
- mem_addr  out  ADDR_WIDTH  memory address; bits [1:0] forced to 0
- mem_wdata  out  DATA_WIDTH  memory write word
- mem_rdata  in  DATA_WIDTH  combinational memory read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- Request latch fields: owner, we, addr, wdata, be.
- Reset values: state = IDLE, last_grant = 1, all latches 0, rsp*_valid = 0, rsp*_rdata = 0, mem_wen = 0, mem_ren = 0, mem_addr = 0, mem_wdata = 0, busy = 0. req*_ready is forced to 0 while rst is high.
- IDLE:
  - reqN_ready = (state == IDLE) && grant == N, combinational.
  - With a single valid request, that port wins.
  - With both valid, the port != last_grant wins. After reset port 0 wins first.
  - On acceptance: latch the request, update last_grant, go to ACCESS.
  - No memory enables are asserted in IDLE.
- ACCESS:
  - mem_ren = 1 and mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - The old word is captured from mem_rdata into rdata_q.
  - Read: go to RESP.
  - Write, be == 4'hF: mem_wen = 1, mem_wdata = wdata, go to RESP.
  - Write, be == 4'h0: no mem_wen; go to RESP. The response still returns the old word.
  - Write, partial be: capture merged = per lane (be[i] ? wdata lane : mem_rdata lane), go to MERGE_WR.
- MERGE_WR: mem_wen = 1, mem_wdata = merged, mem_ren = 0, go to RESP.
- RESP: rsp<owner>_valid = 1 for exactly one cycle, rsp<owner>_rdata = rdata_q. Go to IDLE; no re-arbitration in RESP.
- rsp*_rdata holds its last value after the pulse. The non-owner response port stays at 0 valid.
- Latency, with acceptance in cycle T:
  - Read, full write or be = 0 write: rsp_valid at T+2.
  - Partial write: rsp_valid at T+3.
  - Minimum spacing between acceptances: 3 cycles (4 for partial writes).
- Memory outputs are combinational from state and latches. mem_wen is never high outside ACCESS/MERGE_WR, and never high in two consecutive cycles for one transaction.
- A requester holding valid while not granted keeps its request; no starvation.
  - Under continuous contention, grants alternate 0, 1, 0, 1.
  - A request arriving while busy waits for IDLE.
- Reset asserted mid-transaction: immediate return to IDLE. The in-flight transaction is dropped with no response. mem_wen drops asynchronously, so a pending MERGE_WR write does not occur.
- Back-to-back same-address transactions are coherent: each ACCESS reads the memory after the previous write edge.

Test Plan:
- Reset, then req0 read at 0x10 with mem word 0xDEADBEEF -> req0_ready in cycle T, mem_ren in T+1, rsp0_valid in T+2 with rsp0_rdata = 0xDEADBEEF; rsp1_valid stays 0.
- req1 write addr 0x20, be = 4'hF, wdata 0x12345678 -> mem_wen for exactly one cycle at T+1 with mem_addr 0x20 and mem_wdata 0x12345678; rsp1_valid at T+2.
- Word 0x11223344 at 0x24; req0 write be = 4'b0010, wdata 0x0000AA00 -> single mem_wen in T+2 with mem_wdata 0x1122AA44; rsp0 at T+3 returns 0x11223344.
- Both ports hold valid continuously for 6 transactions -> grant order 0, 1, 0, 1, 0, 1, and each rsp pulse goes only to its owner.
- Write with be = 0 at 0x30 -> no mem_wen; rsp at T+2. Write at address 0x33 -> mem_addr = 0x30.
- Assert rst during MERGE_WR -> mem_wen goes low, no response is issued, busy = 0, and the memory word is unchanged. After release, port 0 wins a simultaneous request.
